tb_sqi_mem: RTL and testbench

Parametrised quad-SPI (SQI) serial SRAM model for the cocotb bench, attached to `tt_um_theultimat_idli_top`'s `uio_*` pins next to the DUT. It serves `NUM_CS` independent byte-addressed memories behind separate active-low chip selects. It decodes READ and WRITE commands nibble-serially, with address auto-increment and wrap. A backdoor port lets the bench preload and inspect memory without SPI traffic.

---
 rtl/tb_sqi_mem_pkg.sv | 22 ++
 rtl/tb_sqi_mem_array.sv | 68 ++++++
 rtl/tb_sqi_mem.sv | 247 ++++++++++++++++++++++++
 tb/tb_tb_sqi_mem.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_sqi_mem_pkg.sv
// Shared types and constants for the SQI serial SRAM bench model.
package tb_sqi_mem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_RD,
        ST_WR,
        ST_IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;

    // Number of SQI nibbles needed to shift in an address of addr_w bits.
    function automatic int addr_nibbles(input int addr_w);
        return addr_w / 4;
    endfunction

endpackage

// File: rtl/tb_sqi_mem_array.sv
// Banked byte RAM: SPI port (sync write, async read) and optional backdoor port
// (sync read/write, enabled by TB_SQI_MEM_BACKDOOR_EN). The backdoor write wins on a same-byte collision.
module tb_sqi_mem_array #(
    parameter int NUM_CS = 2,
    parameter int ADDR_W = 16,
    parameter int BANK_W = 1
) (
    input  logic              clk,
    input  logic              spi_we,
    input  logic [BANK_W-1:0] spi_bank,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [7:0]        spi_wdata,
    output logic [7:0]        spi_rdata
`ifdef TB_SQI_MEM_BACKDOOR_EN
    ,
    input  logic              rst,
    input  logic              bd_en,
    input  logic              bd_we,
    input  logic [BANK_W-1:0] bd_cs,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [7:0]        bd_wdata,
    output logic [7:0]        bd_rdata
`endif
);

    localparam int IDX_W = BANK_W + ADDR_W;
    localparam int DEPTH = 1 << IDX_W;

    logic [IDX_W-1:0] spi_idx;
    assign spi_idx = {spi_bank, spi_addr};

`ifdef TB_SQI_MEM_BACKDOOR_EN
    logic [7:0] mem [DEPTH];

    logic [IDX_W-1:0] bd_idx;
    assign bd_idx = {bd_cs, bd_addr};

    // The backdoor assignment comes last so it overrides an SPI write to the same byte.
    always_ff @(posedge clk) begin
        if (spi_we) begin
            mem[spi_idx] <= spi_wdata;
        end
        if (bd_en && bd_we) begin
            mem[bd_idx] <= bd_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bd_rdata <= 8'h00;
        end else if (bd_en) begin
            bd_rdata <= mem[bd_idx];
        end
    end
`else
    // Without a backdoor there is no way to preload, so memory powers up cleared.
    logic [7:0] mem [DEPTH] = '{default: 8'h00};

    always_ff @(posedge clk) begin
        if (spi_we) begin
            mem[spi_idx] <= spi_wdata;
        end
    end
`endif

    assign spi_rdata = mem[spi_idx];

endmodule

// File: rtl/tb_sqi_mem.sv
// Quad-SPI serial SRAM model with NUM_CS banks; backdoor ports under TB_SQI_MEM_BACKDOOR_EN.
module tb_sqi_mem
    import tb_sqi_mem_pkg::*;
#(
    parameter int NUM_CS    = 2,
    parameter int ADDR_W    = 16,
    parameter int DUMMY_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic [NUM_CS-1:0] cs_n,
    input  logic [3:0]        sio_in,
    output logic [3:0]        sio_out,
    output logic [3:0]        sio_oe,
    output logic              err
`ifdef TB_SQI_MEM_BACKDOOR_EN
    ,
    input  logic                                        bd_en,
    input  logic                                        bd_we,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] bd_cs,
    input  logic [ADDR_W-1:0]                           bd_addr,
    input  logic [7:0]                                  bd_wdata,
    output logic [7:0]                                  bd_rdata
`endif
);

    localparam int BANK_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int ADDR_NIB = addr_nibbles(ADDR_W);
    localparam int CNT_W    = 16;
    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_NIB - 1);
    localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'(DUMMY_CYC - 1);

    logic sck_q;
    logic rise;
    logic fall;

    state_t            state_reg,   state_next;
    logic [CNT_W-1:0]  cnt_reg,     cnt_next;
    logic [3:0]        cmd_hi_reg,  cmd_hi_next;
    logic              is_read_reg, is_read_next;
    logic [ADDR_W-1:0] addr_reg,    addr_next;
    logic [BANK_W-1:0] bank_reg,    bank_next;
    logic              nib_reg,     nib_next;
    logic [3:0]        wr_hi_reg,   wr_hi_next;
    logic [3:0]        sio_out_reg, sio_out_next;
    logic              err_reg,     err_next;

    logic              any_sel;
    logic              multi_sel;
    logic [NUM_CS-1:0] first_low;
    logic [BANK_W-1:0] low_idx;

    logic              spi_we;
    logic [7:0]        spi_wdata;
    logic [7:0]        spi_rdata;

    assign rise = sck & ~sck_q;
    assign fall = ~sck & sck_q;

    assign any_sel   = ~&cs_n;
    assign multi_sel = ($countones(~cs_n) > 1);

    // One-hot marker of the lowest-index asserted chip select.
    generate
        for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_first_low
            if (gi == 0) begin : g_lsb
                assign first_low[gi] = ~cs_n[gi];
            end else begin : g_upper
                assign first_low[gi] = ~cs_n[gi] & (&cs_n[gi-1:0]);
            end
        end
    endgenerate

    always_comb begin
        low_idx = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (first_low[i]) begin
                low_idx = BANK_W'(i);
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cmd_hi_next  = cmd_hi_reg;
        is_read_next = is_read_reg;
        addr_next    = addr_reg;
        bank_next    = bank_reg;
        nib_next     = nib_reg;
        wr_hi_next   = wr_hi_reg;
        sio_out_next = sio_out_reg;
        err_next     = err_reg | multi_sel;
        spi_we       = 1'b0;
        spi_wdata    = {wr_hi_reg, sio_in};

        // Deselect aborts everything, including a half-assembled write byte.
        if (!any_sel) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
            nib_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_CMD;
                    bank_next  = low_idx;
                    cnt_next   = '0;
                    nib_next   = 1'b0;
                end
                ST_CMD: begin
                    if (rise) begin
                        if (cnt_reg == '0) begin
                            cmd_hi_next = sio_in;
                            cnt_next    = CNT_W'(1);
                        end else begin
                            cnt_next = '0;
                            if ({cmd_hi_reg, sio_in} == CMD_READ) begin
                                is_read_next = 1'b1;
                                state_next   = ST_ADDR;
                            end else if ({cmd_hi_reg, sio_in} == CMD_WRITE) begin
                                is_read_next = 1'b0;
                                state_next   = ST_ADDR;
                            end else begin
                                state_next = ST_IGNORE;
                                err_next   = 1'b1;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (rise) begin
                        addr_next = {addr_reg[ADDR_W-5:0], sio_in};
                        if (cnt_reg == ADDR_LAST) begin
                            cnt_next = '0;
                            nib_next = 1'b0;
                            if (!is_read_reg) begin
                                state_next = ST_WR;
                            end else if (DUMMY_CYC == 0) begin
                                state_next = ST_RD;
                            end else begin
                                state_next = ST_DUMMY;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_DUMMY: begin
                    if (rise) begin
                        if (cnt_reg == DUMMY_LAST) begin
                            cnt_next   = '0;
                            state_next = ST_RD;
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end
                ST_RD: begin
                    if (fall) begin
                        sio_out_next = nib_reg ? spi_rdata[3:0] : spi_rdata[7:4];
                    end
                    if (rise) begin
                        nib_next = ~nib_reg;
                        if (nib_reg) begin
                            addr_next = addr_reg + ADDR_W'(1);
                        end
                    end
                end
                ST_WR: begin
                    if (rise) begin
                        if (!nib_reg) begin
                            wr_hi_next = sio_in;
                            nib_next   = 1'b1;
                        end else begin
                            spi_we    = 1'b1;
                            nib_next  = 1'b0;
                            addr_next = addr_reg + ADDR_W'(1);
                        end
                    end
                end
                ST_IGNORE: begin
                    state_next = ST_IGNORE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_q       <= 1'b0;
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            cmd_hi_reg  <= '0;
            is_read_reg <= 1'b0;
            addr_reg    <= '0;
            bank_reg    <= '0;
            nib_reg     <= 1'b0;
            wr_hi_reg   <= '0;
            sio_out_reg <= '0;
            err_reg     <= 1'b0;
        end else begin
            sck_q       <= sck;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            cmd_hi_reg  <= cmd_hi_next;
            is_read_reg <= is_read_next;
            addr_reg    <= addr_next;
            bank_reg    <= bank_next;
            nib_reg     <= nib_next;
            wr_hi_reg   <= wr_hi_next;
            sio_out_reg <= sio_out_next;
            err_reg     <= err_next;
        end
    end

    assign sio_out = sio_out_reg;
    assign sio_oe  = (state_reg == ST_RD) ? 4'hF : 4'h0;
    assign err     = err_reg;

    tb_sqi_mem_array #(
        .NUM_CS (NUM_CS),
        .ADDR_W (ADDR_W),
        .BANK_W (BANK_W)
    ) u_array (
        .clk       (clk),
        .spi_we    (spi_we),
        .spi_bank  (bank_reg),
        .spi_addr  (addr_reg),
        .spi_wdata (spi_wdata),
        .spi_rdata (spi_rdata)
`ifdef TB_SQI_MEM_BACKDOOR_EN
        ,
        .rst       (rst),
        .bd_en     (bd_en),
        .bd_we     (bd_we),
        .bd_cs     (bd_cs),
        .bd_addr   (bd_addr),
        .bd_wdata  (bd_wdata),
        .bd_rdata  (bd_rdata)
`endif
    );

endmodule

// File: tb/tb_tb_sqi_mem.sv
// Scoreboard bench for tb_sqi_mem; uses the backdoor when TB_SQI_MEM_BACKDOOR_EN is defined, SPI otherwise.
module tb_tb_sqi_mem;

    localparam int NUM_CS    = 2;
    localparam int ADDR_W    = 16;
    localparam int DUMMY_CYC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck;
    logic [1:0]  cs_n;
    logic [3:0]  sio_in;
    logic [3:0]  sio_out;
    logic [3:0]  sio_oe;
    logic        err;
`ifdef TB_SQI_MEM_BACKDOOR_EN
    logic        bd_en;
    logic        bd_we;
    logic [0:0]  bd_cs;
    logic [15:0] bd_addr;
    logic [7:0]  bd_wdata;
    logic [7:0]  bd_rdata;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] exp_nib_q [$];
    logic [7:0] exp_bd_q  [$];

    always #5 clk = ~clk;

    tb_sqi_mem #(
        .NUM_CS    (NUM_CS),
        .ADDR_W    (ADDR_W),
        .DUMMY_CYC (DUMMY_CYC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sck      (sck),
        .cs_n     (cs_n),
        .sio_in   (sio_in),
        .sio_out  (sio_out),
        .sio_oe   (sio_oe),
        .err      (err)
`ifdef TB_SQI_MEM_BACKDOOR_EN
        ,
        .bd_en    (bd_en),
        .bd_we    (bd_we),
        .bd_cs    (bd_cs),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .bd_rdata (bd_rdata)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sck_cycle(input logic [3:0] nib);
        step();
        sck    = 1'b0;
        sio_in = nib;
        step();
        sck    = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        sck_cycle(b[7:4]);
        sck_cycle(b[3:0]);
    endtask

    task automatic spi_begin(input logic [1:0] csv);
        step();
        sck  = 1'b0;
        cs_n = csv;
    endtask

    task automatic spi_end();
        step();
        sck = 1'b0;
        step();
        cs_n = 2'b11;
        step();
        step();
    endtask

    task automatic spi_cmd_addr(input logic [1:0] csv, input logic [7:0] cmd, input logic [15:0] addr);
        spi_begin(csv);
        send_byte(cmd);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
    endtask

    task automatic spi_read(input logic [1:0] csv, input logic [15:0] addr, input int n,
                            input logic [31:0] data);
        logic [7:0] b;
        spi_cmd_addr(csv, 8'h03, addr);
        repeat (DUMMY_CYC) sck_cycle(4'h0);
        for (int i = 0; i < n; i++) begin
            b = data[31-8*i -: 8];
            exp_nib_q.push_back(b[7:4]);
            exp_nib_q.push_back(b[3:0]);
            sck_cycle(4'h0);
            sck_cycle(4'h0);
        end
        spi_end();
        check("read nibbles outstanding", exp_nib_q.size(), 0);
    endtask

    task automatic spi_write(input logic [1:0] csv, input logic [15:0] addr, input int n,
                             input logic [31:0] data);
        spi_cmd_addr(csv, 8'h02, addr);
        for (int i = 0; i < n; i++) begin
            send_byte(data[31-8*i -: 8]);
        end
        spi_end();
    endtask

    function automatic logic [1:0] cs_of(input logic bank);
        return bank ? 2'b01 : 2'b10;
    endfunction

    task automatic mem_write(input logic bank, input logic [15:0] addr, input logic [7:0] d);
`ifdef TB_SQI_MEM_BACKDOOR_EN
        step();
        bd_en    = 1'b1;
        bd_we    = 1'b1;
        bd_cs    = bank;
        bd_addr  = addr;
        bd_wdata = d;
        step();
        bd_en = 1'b0;
        bd_we = 1'b0;
`else
        spi_write(cs_of(bank), addr, 1, {d, 24'h0});
`endif
    endtask

    task automatic mem_check(input logic bank, input logic [15:0] addr, input logic [7:0] exp);
`ifdef TB_SQI_MEM_BACKDOOR_EN
        step();
        bd_en   = 1'b1;
        bd_we   = 1'b0;
        bd_cs   = bank;
        bd_addr = addr;
        exp_bd_q.push_back(exp);
        step();
        bd_en = 1'b0;
        step();
`else
        spi_read(cs_of(bank), addr, 1, {exp, 24'h0});
`endif
    endtask

    task automatic pulse_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    // Monitor: checks read nibbles at each SCK rise where the model drives, and backdoor read data.
    initial begin : monitor
        logic       sck_prev;
        logic       bd_pend;
        logic [3:0] e_nib;
        logic [7:0] e_byte;
        sck_prev = 1'b0;
        bd_pend  = 1'b0;
        forever begin
            @(negedge clk);
            if (sck && !sck_prev && sio_oe !== 4'h0) begin
                n_checks++;
                if (sio_oe !== 4'hF) begin
                    n_fail++;
                    $display("FAIL sio_oe partial: got 0x%0h, expected 0xf", sio_oe);
                end else if (exp_nib_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected read nibble: got 0x%0h, expected no drive", sio_out);
                end else begin
                    e_nib = exp_nib_q.pop_front();
                    if (sio_out !== e_nib) begin
                        n_fail++;
                        $display("FAIL read nibble: got 0x%0h, expected 0x%0h", sio_out, e_nib);
                    end
                end
            end
            sck_prev = sck;
`ifdef TB_SQI_MEM_BACKDOOR_EN
            if (bd_pend) begin
                n_checks++;
                if (exp_bd_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL backdoor read: got 0x%0h, expected nothing queued", bd_rdata);
                end else begin
                    e_byte = exp_bd_q.pop_front();
                    if (bd_rdata !== e_byte) begin
                        n_fail++;
                        $display("FAIL backdoor read: got 0x%0h, expected 0x%0h", bd_rdata, e_byte);
                    end
                end
            end
            bd_pend = bd_en && !bd_we;
`else
            bd_pend = 1'b0;
            e_byte  = 8'h00;
`endif
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst    = 1'b1;
        sck    = 1'b0;
        cs_n   = 2'b11;
        sio_in = 4'h0;
`ifdef TB_SQI_MEM_BACKDOOR_EN
        bd_en    = 1'b0;
        bd_we    = 1'b0;
        bd_cs    = 1'b0;
        bd_addr  = 16'h0;
        bd_wdata = 8'h0;
`endif
        repeat (3) step();
        rst = 1'b0;
        step();
        check("reset sio_out", sio_out, 0);
        check("reset sio_oe", sio_oe, 0);
        check("reset err", err, 0);
`ifdef TB_SQI_MEM_BACKDOOR_EN
        check("reset bd_rdata", bd_rdata, 0);
`endif
        $display("reset checks done");

        // Preload, then SPI read of two bytes across the dummy phase.
        mem_write(1'b0, 16'h0010, 8'hA5);
        mem_write(1'b0, 16'h0011, 8'h3C);
        mem_write(1'b0, 16'hFFFF, 8'h77);
        mem_write(1'b0, 16'h0000, 8'h66);
        mem_write(1'b1, 16'h0011, 8'hE1);
        spi_read(2'b10, 16'h0010, 2, 32'hA53C_0000);
        check("err after clean read", err, 0);
        $display("read bank0 0x0010 done");

        // Write across the top of bank1: second byte wraps to 0x0000.
        spi_write(2'b01, 16'hFFFF, 2, 32'h1234_0000);
        mem_check(1'b1, 16'hFFFF, 8'h12);
        mem_check(1'b1, 16'h0000, 8'h34);
        mem_check(1'b0, 16'hFFFF, 8'h77);
        mem_check(1'b0, 16'h0000, 8'h66);
        $display("wrap write bank1 done");

        // Partial write: deselect after three nibbles.
        mem_write(1'b0, 16'h0020, 8'h11);
        mem_write(1'b0, 16'h0021, 8'h22);
        spi_cmd_addr(2'b10, 8'h02, 16'h0020);
        send_byte(8'hB7);
        sck_cycle(4'hC);
        spi_end();
        mem_check(1'b0, 16'h0020, 8'hB7);
        mem_check(1'b0, 16'h0021, 8'h22);
        spi_read(2'b10, 16'h0020, 1, 32'hB700_0000);
        check("err after partial write", err, 0);
        $display("partial write done");

        // Unknown command: ignored, sticky error until reset.
        spi_cmd_addr(2'b10, 8'h9F, 16'h0010);
        check("sio_oe in ignore", sio_oe, 0);
        check("err after bad command", err, 1);
        spi_end();
        spi_read(2'b10, 16'h0010, 1, 32'hA500_0000);
        check("err sticky", err, 1);
        pulse_reset();
        check("err cleared by reset", err, 0);
        $display("ignore command done");

        // Both chip selects low: bank0 served, error flagged.
        spi_read(2'b00, 16'h0011, 1, 32'h3C00_0000);
        check("err on multi cs", err, 1);
        pulse_reset();
        $display("multi cs done");

        // Reset in the middle of a read data phase.
        spi_cmd_addr(2'b10, 8'h03, 16'h0010);
        repeat (DUMMY_CYC) sck_cycle(4'h0);
        exp_nib_q.push_back(4'hA);
        sck_cycle(4'h0);
        step();
        rst  = 1'b1;
        sck  = 1'b0;
        cs_n = 2'b11;
        step();
        check("sio_oe after mid-read reset", sio_oe, 0);
        check("sio_out after mid-read reset", sio_out, 0);
        check("err after mid-read reset", err, 0);
        rst = 1'b0;
        step();
        check("nibbles before reset", exp_nib_q.size(), 0);
        mem_check(1'b0, 16'h0010, 8'hA5);
        mem_check(1'b0, 16'h0011, 8'h3C);
        step();
        step();
        check("backdoor queue drained", exp_bd_q.size(), 0);
        $display("mid-read reset done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
